// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive front end: receiver FSM state
// encoding, oversampling constants and the baud divider helper.
// Used by: uart_rx_stream, uart_rx_fifo.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  // Receiver FSM states. PARITY is only reachable when the design is built
  // with UART_RX_PARITY_EN defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Ticks per bit period and the tick on which each bit is sampled.
  localparam int OVERSAMPLE  = 16;
  localparam int SAMPLE_TICK = 8;
  localparam int TICK_W      = $clog2(OVERSAMPLE);

  // Clock cycles per oversampling tick, rounded down and never below one.
  function automatic int calc_div(input int frequency, input int baudrate);
    int d;
    d = frequency / (baudrate * OVERSAMPLE);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous first-word-fall-through FIFO holding received characters.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   push       write push_data (ignored when full unless pop is also set)
//   push_data  character to store
//   pop        consume the head entry (ignored when empty)
//   rdata      head entry; holds the last popped value while empty
//   empty      no entries stored
//   full       fifo_depth entries stored
//
// fifo_depth must be a power of two, minimum 2.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int data_width = 8,
  parameter int fifo_depth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [data_width-1:0] rdata,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(fifo_depth);

  logic [data_width-1:0] mem [fifo_depth];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [data_width-1:0] last_rdata;
  logic                  do_push;
  logic                  do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // that differ only in the wrap bit mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO is still accepted when the head is popped in the
  // same cycle, because the slot being written is the one being freed.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // While empty the output keeps showing the last character handed out
  // instead of whatever stale entry the read pointer now addresses.
  assign rdata = empty ? last_rdata : mem[rd_ptr[AW-1:0]];

  // Storage array; no reset needed since entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer bookkeeping and the held copy of the most recently popped entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_rdata <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        last_rdata <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// -----------------------------------------------------------------------------
// uart_rx_stream
// UART receive front end: synchronises the rx line, oversamples it at 16x
// baud, deframes 8N1 characters (8E1 when UART_RX_PARITY_EN is defined) and
// buffers them in a FWFT FIFO with a valid/ready output stream.
//
// Build option:
//   UART_RX_PARITY_EN  adds an even-parity bit after the data bits; a parity
//                      mismatch drops the character and raises frame_err at
//                      the stop-bit sample.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx         asynchronous serial line, idle high
//   rdata      head-of-FIFO character
//   rvalid     FIFO not empty
//   rready     consumer accepts rdata this cycle
//   frame_err  one-cycle pulse: bad stop bit (or parity)
//   overrun    one-cycle pulse: complete character dropped, FIFO full
//   busy       receiver FSM not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_stream
  import uart_rx_pkg::*;
#(
  parameter int frequency  = 66000000,
  parameter int baudrate   = 115200,
  parameter int data_width = 8,
  parameter int fifo_depth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [data_width-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int DIV      = calc_div(frequency, baudrate);
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W    = (data_width > 1) ? $clog2(data_width) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] START_LAST  = TICK_W'(SAMPLE_TICK - 1);
  localparam logic [TICK_W-1:0] BIT_LAST    = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BITS_LAST   = BIT_W'(data_width - 1);

  rx_state_t             state;
  logic                  rx_meta;
  logic                  rx_s;
  logic                  rx_prev;
  logic                  rx_fall;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [data_width-1:0] shift_reg;
  logic                  bit_sample;
  logic                  parity_bad;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  // All flops preset to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall = rx_prev && !rx_s;

  // Free-running oversampling tick divider, realigned to the start edge so
  // every character is sampled at the same phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if ((state == IDLE) && rx_fall) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // After the start bit has been sampled at its midpoint the tick counter is
  // cleared, so a full 16-tick period lands on the middle of every later bit.
  assign bit_sample = tick && (tick_cnt == BIT_LAST);

`ifndef UART_RX_PARITY_EN
  assign parity_bad = 1'b0;
`endif

  // Receiver FSM: start validation, data shifting (LSB first), optional
  // parity, stop check and break hold-off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_fall) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == START_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_sample) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[data_width-1:1]};
              if (bit_cnt == BITS_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (bit_sample) begin
              tick_cnt   <= '0;
              parity_bad <= ^{shift_reg, rx_s};
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_sample) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end else begin
                frame_err <= parity_bad;
                state     <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The push is taken straight from the stop-sample cycle so the character
  // is visible on rvalid one clock later.
  assign push   = (state == STOP) && bit_sample && rx_s && !parity_bad;
  assign pop    = rvalid && rready;
  assign rvalid = !fifo_empty;
  assign busy   = (state != IDLE);

  // Overrun only when the FIFO cannot make room by popping in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= push && fifo_full && !pop;
    end
  end

  uart_rx_fifo #(
    .data_width (data_width),
    .fifo_depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_reg),
    .pop       (pop),
    .rdata     (rdata),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
Serial receive front end feeding the rdata/rvalid/rready byte stream that the ASCII classifier and the ucmd FSM consume.
- Oversamples the rx line at 16x baud, deframes 8N1 (or 8E1, optional) characters and buffers them in a small FIFO.
- Exposes a first-word-fall-through valid/ready interface.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
frequency, 66000000, clk frequency in Hz
baudrate, 115200, line rate in bit/s
data_width, 8, data bits per character (LSB first)
fifo_depth, 16, receive FIFO entries; power of two, minimum 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
rx  input  1  asynchronous serial line, idle high
rdata  output  data_width  head-of-FIFO character
rvalid  output  1  FIFO not empty
rready  input  1  consumer accepts rdata this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: complete character dropped, FIFO full
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; tick counter, bit counter, FIFO pointers cleared.
  - rvalid=0, rdata=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops preset to 1.
- Reset mid-character: the partial character is discarded. After release, reception resumes only at the next falling edge seen in IDLE.
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
- Tick generator:
  - DIV = frequency/(baudrate*16), integer floor, minimum 1.
  - One tick pulse every DIV clk cycles, free-running; restarted when leaving IDLE.
  - One bit period = 16 ticks; sample point = tick 8 of each bit.
- FSM states:
  - IDLE: rx_s falling edge (1->0) -> START, tick count = 0.
  - START: at tick 8, if rx_s=1 the edge was a glitch -> IDLE (no error). If rx_s=0 -> DATA with bit count 0, tick count reset.
  - DATA: at tick 8 of each bit, shift rx_s into the shift register MSB, shift right. After data_width bits -> STOP (or PARITY if enabled).
  - STOP: at tick 8:
    - rx_s=1: push the character into the FIFO -> IDLE.
    - rx_s=0: frame_err pulses one cycle, character discarded -> BREAK.
  - BREAK: wait for rx_s=1 -> IDLE. Prevents a held-low line generating repeated characters.
- Sampling: single sample at tick 8 (majority vote is not required).
- FIFO:
  - First-word fall through: rdata is valid in the same cycle as rvalid.
  - Pop on rvalid && rready.
  - Push latency: a character becomes visible on rvalid one clk after the stop-bit sample cycle.
  - Full and push without pop: character dropped, overrun pulses, FIFO unchanged.
  - Full and push with simultaneous pop: both occur, no overrun, count unchanged.
  - Empty with rready=1: no effect; rdata holds its last value.
  - Pointers are log2(fifo_depth)+1 bits with natural wrap; full/empty use the MSB-differ compare.
- busy = 1 in any state other than IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA; the bit sampled at tick 8 must make total ones even.
  - On mismatch, the character is discarded at STOP (not pushed) and the frame_err pulse is raised at the stop sample.
  - Frame length is 11 bits.
- Undefined: no PARITY state; 8N1 framing, 10-bit frame.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state encoding constants: IDLE, START, DATA, PARITY, STOP, BREAK;
  - OVERSAMPLE=16, SAMPLE_TICK=8.
- One sub-module, uart_rx_fifo: parameterised synchronous FIFO (data_width, fifo_depth) with FWFT output, push/pop/full/empty. The top module holds the synchronizer, tick generator and FSM.

Test Plan:
- Single character: frequency=1843200, baudrate=115200 (DIV=1, 16 clk/bit), rx frame for 0x55, rready=1.
  -> rvalid high for exactly 1 cycle with rdata=0x55, one clk after the stop sample (clk 152 after the start edge + 2 sync cycles); no error pulses.
- Overrun: rready=0, send 17 characters 0x00..0x10 with fifo_depth=16.
  -> overrun pulses once on the 17th character; draining yields 0x00..0x0F in order, then rvalid=0.
- Framing: send 0xA3 with stop bit held low for 40 clks, then idle.
  -> frame_err pulses once, nothing pushed, busy stays 1 until rx returns high, no spurious character.
- Glitch: rx low for 4 clks, then high.
  -> FSM returns to IDLE at the start mid-sample, no push, no frame_err.
- Reset mid-frame: assert rst low during bit 3 of 0x7E, release, then send 0x41.
  -> outputs zero immediately; only 0x41 appears.
- Full plus simultaneous pop: FIFO full and rready=1 in the push cycle.
  -> no overrun, count stays 16, head advances.
- Parity (build with UART_RX_PARITY_EN): 0x07 with parity bit 0 -> frame_err, no push; same character with parity bit 1 -> rdata=0x07.
